// File: rtl/rr_mux_arbiter_8.sv
// rtl/rr_mux_arbiter_8.sv - 8-way round-robin arbiter with burst-limited grants and data mux
// A grant lasts up to BURST transfers, then one IDLE cycle before the next arbitration.
module rr_mux_arbiter_8 #(
   parameter int DATA_W = 8,
   parameter int BURST  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          req,
   input  logic [8*DATA_W-1:0] in_data,
   input  logic                out_ready,
   output logic [7:0]          gnt,
   output logic [2:0]          sel,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data
);

   localparam int BEAT_W = $clog2(BURST) + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          ptr_q, ptr_d;
   logic [2:0]          sel_q, sel_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [2:0]          winner;
   logic [2:0]          idx;
   logic                xfer;

   // Scan from farthest to nearest so the nearest set bit after ptr wins;
   // k=8 revisits ptr itself, letting it win only when it is the sole requester.
   always_comb begin
      winner = ptr_q;
      idx    = ptr_q;
      for (int k = 8; k >= 1; k--) begin
         idx = ptr_q + 3'(k);
         if (req[idx]) winner = idx;
      end
   end

   assign out_valid = (state_q == GRANT) & req[sel_q];
   assign xfer      = out_valid & out_ready;
   assign gnt       = (state_q == GRANT) ? (8'd1 << sel_q) : 8'd0;
   assign sel       = sel_q;
   assign out_data  = in_data[sel_q*DATA_W +: DATA_W];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               sel_d   = winner;
               ptr_d   = winner;
               beat_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!req[sel_q]) begin
               state_d = IDLE;
            end else if (xfer) begin
               beat_d = beat_q + 1'b1;
               if (beat_d == BEAT_W'(BURST)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 3'd7;
         sel_q   <= 3'd0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// tb/tb_rr_mux_arbiter_8.sv - directed self-checking bench for rr_mux_arbiter_8
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_rr_mux_arbiter_8;

   logic        clk;
   logic        rst_n;
   logic [7:0]  req;
   logic [63:0] in_data;
   logic        out_ready;
   logic [7:0]  gnt, gnt1;
   logic [2:0]  sel, sel1;
   logic        out_valid, out_valid1;
   logic [7:0]  out_data, out_data1;

   int checks;
   int errors;

   rr_mux_arbiter_8 #(.DATA_W(8), .BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .out_ready(out_ready),
      .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data)
   );

   rr_mux_arbiter_8 #(.DATA_W(8), .BURST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .out_ready(out_ready),
      .gnt(gnt1), .sel(sel1), .out_valid(out_valid1), .out_data(out_data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req       = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h expected 00", gnt); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
      checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL reset_data: got %h expected 3c", out_data); end
      checks++; if (gnt1 !== 8'h00) begin errors++; $display("FAIL reset_gnt1: got %h expected 00", gnt1); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL idle_no_req: got %h expected 00", gnt); end
   endtask

   task automatic test_single();
      do_reset();
      req       = 8'h04;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (sel !== 3'd2) begin errors++; $display("FAIL single_sel: got %0d expected 2", sel); end
      checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", out_data); end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         checks++; if (gnt !== 8'h04 || out_valid !== 1'b1)
            begin errors++; $display("FAIL single_beat%0d: gnt %h valid %b expected 04 1", i, gnt, out_valid); end
      end
      @(negedge clk);
      checks++; if (gnt !== 8'h00 || out_valid !== 1'b0)
         begin errors++; $display("FAIL single_bubble: gnt %h valid %b expected 00 0", gnt, out_valid); end
      @(negedge clk);
      checks++; if (gnt !== 8'h04 || sel !== 3'd2)
         begin errors++; $display("FAIL single_regrant: gnt %h sel %0d expected 04 2", gnt, sel); end
      req = 8'h00;
      @(negedge clk);
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL single_release: got %h expected 00", gnt); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_sel [0:8];
      exp_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      do_reset();
      req       = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         checks++; if (sel1 !== exp_sel[k] || gnt1 !== (8'd1 << exp_sel[k]) || out_valid1 !== 1'b1)
            begin errors++; $display("FAIL rr_grant%0d: sel %0d gnt %h valid %b expected sel %0d", k, sel1, gnt1, out_valid1, exp_sel[k]); end
         @(negedge clk);
         checks++; if (gnt1 !== 8'h00)
            begin errors++; $display("FAIL rr_bubble%0d: gnt %h expected 00", k, gnt1); end
      end
   endtask

   task automatic test_backpressure();
      int n_xfer;
      do_reset();
      req       = 8'h10;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (gnt !== 8'h10 || out_valid !== 1'b1 || sel !== 3'd4)
            begin errors++; $display("FAIL bp_hold%0d: gnt %h valid %b sel %0d expected 10 1 4", c, gnt, out_valid, sel); end
      end
      out_ready = 1'b1;
      n_xfer = 0;
      for (int c = 0; c < 10 && gnt != 8'h00; c++) begin
         if (out_valid && out_ready) n_xfer++;
         @(negedge clk);
      end
      checks++; if (n_xfer != 4) begin errors++; $display("FAIL bp_count: got %0d transfers expected 4", n_xfer); end
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL bp_end: got %h expected 00", gnt); end
   endtask

   task automatic test_early_drop();
      do_reset();
      req       = 8'h21;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL drop_first: got %h expected 01", gnt); end
      @(negedge clk);
      checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL drop_second: got %h expected 01", gnt); end
      @(negedge clk);
      req = 8'h20;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b expected 0", out_valid); end
      @(negedge clk);
      checks++; if (gnt !== 8'h00 || out_valid !== 1'b0)
         begin errors++; $display("FAIL drop_idle: gnt %h valid %b expected 00 0", gnt, out_valid); end
      @(negedge clk);
      checks++; if (sel !== 3'd5 || gnt !== 8'h20)
         begin errors++; $display("FAIL drop_next: sel %0d gnt %h expected 5 20", sel, gnt); end
   endtask

   task automatic test_wrap();
      do_reset();
      req       = 8'h40;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (sel !== 3'd6) begin errors++; $display("FAIL wrap_setup: got %0d expected 6", sel); end
      req = 8'h41;
      @(negedge clk);
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL wrap_bubble: got %h expected 00", gnt); end
      @(negedge clk);
      checks++; if (sel !== 3'd0 || gnt !== 8'h01)
         begin errors++; $display("FAIL wrap_grant: sel %0d gnt %h expected 0 01", sel, gnt); end
   endtask

   task automatic test_async_reset();
      do_reset();
      req       = 8'h08;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL areset_pre: got %h expected 08", gnt); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (gnt !== 8'h00 || out_valid !== 1'b0)
         begin errors++; $display("FAIL areset_now: gnt %h valid %b expected 00 0", gnt, out_valid); end
      checks++; if (sel !== 3'd0) begin errors++; $display("FAIL areset_sel: got %0d expected 0", sel); end
      #1 rst_n = 1'b1;
      req = 8'h81;
      @(negedge clk);
      checks++; if (sel !== 3'd0 || gnt !== 8'h01)
         begin errors++; $display("FAIL areset_regrant: sel %0d gnt %h expected 0 01", sel, gnt); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      req       = 8'h00;
      out_ready = 1'b0;
      in_data   = 64'h7766_5544_33A5_113C;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_early_drop();
      test_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
